// File: rtl/reg_read_stage.sv
// reg_read_stage: operand fetch with a 1-entry output buffer that snoops write-back so operands never go stale
module reg_read_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [ADDR_W-1:0] rf_addr_a,
  output logic [ADDR_W-1:0] rf_addr_b,
  input  logic [DATA_W-1:0] rf_data_a,
  input  logic [DATA_W-1:0] rf_data_b,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic [ADDR_W-1:0] out_rs1,
  output logic [ADDR_W-1:0] out_rs2
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nx;
  logic accept, stall, upd_a, upd_b;
  logic [DATA_W-1:0] cap_a, cap_b;
  assign rf_addr_a = rs1;
  assign rf_addr_b = rs2;
  assign accept = req_valid & req_ready;
  assign stall  = out_valid & ~out_ready;
  // capture: hard zero wins over the same-cycle write-back bypass, which wins over the regfile
  assign cap_a = (ZERO_REG && rs1 == '0) ? '0 : (wb_we && wb_addr == rs1) ? wb_data : rf_data_a;
  assign cap_b = (ZERO_REG && rs2 == '0) ? '0 : (wb_we && wb_addr == rs2) ? wb_data : rf_data_b;
  // a stalled operand follows any write-back to its register
  assign upd_a = stall & wb_we & (wb_addr == out_rs1) & ~(ZERO_REG && out_rs1 == '0);
  assign upd_b = stall & wb_we & (wb_addr == out_rs2) & ~(ZERO_REG && out_rs2 == '0);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= EMPTY;
    else        state <= state_nx;
  always_comb
    state_nx = accept ? FULL : out_ready ? EMPTY : state;
  always_comb begin
    out_valid = state == FULL;
    req_ready = state == EMPTY || out_ready;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      op_a    <= '0;
      op_b    <= '0;
      out_rs1 <= '0;
      out_rs2 <= '0;
    end else if (accept) begin
      op_a    <= cap_a;
      op_b    <= cap_b;
      out_rs1 <= rs1;
      out_rs2 <= rs2;
    end else begin
      op_a <= upd_a ? wb_data : op_a;
      op_b <= upd_b ? wb_data : op_b;
    end
endmodule

// File: tb/tb_reg_read_stage.sv
// tb_reg_read_stage: random plus directed stimulus; a queue scoreboard checks each held operand
// against the live architectural register value of the request that produced it
module tb_reg_read_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [4:0] rs1 = '0, rs2 = '0, rf_addr_a, rf_addr_b;
  logic [31:0] rf_data_a, rf_data_b;
  logic wb_we = 1'b0;
  logic [4:0] wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic out_valid, out_ready = 1'b0;
  logic [31:0] op_a, op_b;
  logic [4:0] out_rs1, out_rs2;
  logic [31:0] rf [32] = '{default: 32'h0};
  typedef struct {logic [4:0] a; logic [4:0] b;} req_t;
  req_t q[$];
  int n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, n_disc = 0;

  reg_read_stage dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .rs1(rs1), .rs2(rs2), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b),
    .out_rs1(out_rs1), .out_rs2(out_rs2)
  );

  always #5 clk = ~clk;

  // behavioural regfile: combinational read, write on the rising edge
  assign rf_data_a = rf[rf_addr_a];
  assign rf_data_b = rf[rf_addr_b];
  always @(posedge clk) if (wb_we) rf[wb_addr] <= wb_data;

  function automatic logic [31:0] arch(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : rf[r];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: operands must equal the current register contents until the handshake completes
  always @(negedge clk) if (reset) begin
    logic exp_ready;
    exp_ready = (q.size() == 0) || out_ready;
    chk("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
    chk("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    if (out_valid && q.size() != 0) begin
      chk("out_rs1", {27'b0, out_rs1}, {27'b0, q[0].a});
      chk("out_rs2", {27'b0, out_rs2}, {27'b0, q[0].b});
      chk("op_a", op_a, arch(q[0].a));
      chk("op_b", op_b, arch(q[0].b));
      if (out_ready) begin
        void'(q.pop_front());
        n_pop++;
      end
    end
    if (req_valid && exp_ready) begin
      q.push_back('{a: rs1, b: rs2});
      n_push++;
    end
  end

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic we,
                       input logic [4:0] wa, input logic [31:0] wd, input logic rdy);
    req_valid = v; rs1 = a; rs2 = b; wb_we = we; wb_addr = wa; wb_data = wd; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] wa, input logic [31:0] wd);
    drive(1'b0, 5'd0, 5'd0, 1'b1, wa, wd, 1'b1);
  endtask

  initial begin
    #12 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    chk("rst_op_a", op_a, 32'h0);
    chk("rst_out_rs1", {27'b0, out_rs1}, 32'h0);
    // reset while stalled with a held operand
    wr(5'd3, 32'h1234);
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0);
    chk("stall_op_a", op_a, 32'h1234);
    reset = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, out_valid}, 32'h0);
    chk("async_op_a", op_a, 32'h0);
    n_disc += q.size();
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, req_ready}, 32'h1);
    @(posedge clk); #1;
    // basic read and back-to-back throughput
    wr(5'd3, 32'hAAAA5555);
    wr(5'd7, 32'h0000FFFF);
    drive(1'b1, 5'd3, 5'd7, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("t2_op_a", op_a, 32'hAAAA5555);
    chk("t2_op_b", op_b, 32'h0000FFFF);
    for (int i = 0; i < 4; i++) drive(1'b1, 5'd7, 5'd3, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("t2_b2b_valid", {31'b0, out_valid}, 32'h1);
    // same-cycle bypass into both operands
    wr(5'd5, 32'h1);
    drive(1'b1, 5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1);
    chk("t3_op_a", op_a, 32'hDEADBEEF);
    chk("t3_op_b", op_b, 32'hDEADBEEF);
    // held operand follows write-back during a stall
    drive(1'b1, 5'd3, 5'd9, 1'b0, 5'd0, 32'h0, 1'b1);
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 32'h42, 1'b0);
    chk("t4_op_b", op_b, 32'h42);
    chk("t4_op_a", op_a, 32'hAAAA5555);
    chk("t4_ready", {31'b0, req_ready}, 32'h0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("t4_empty", {31'b0, out_valid}, 32'h0);
    // register zero reads as zero and ignores bypass
    wr(5'd0, 32'hFFFFFFFF);
    drive(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 32'h99, 1'b1);
    chk("t5_op_a", op_a, 32'h0);
    // drain plus accept plus write-back to the draining register
    wr(5'd4, 32'h11);
    drive(1'b1, 5'd4, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("t6_old_op_a", op_a, 32'h11);
    drive(1'b1, 5'd4, 5'd4, 1'b1, 5'd4, 32'h22, 1'b1);
    chk("t6_new_op_a", op_a, 32'h22);
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(0, 99) < 70), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 99) < 60));
    for (int i = 0; i < 3; i++) drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b1);
    chk("sb_empty", q.size(), 32'h0);
    chk("sb_count", n_push, n_pop + n_disc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
